// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM command arbiter: command encodings, FSM states, refresh default.
// Optional round-robin WR/RD arbitration is enabled with `define SDRAM_ARB_RR_EN.
package sdram_arbit_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MSET = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    localparam int REF_CYCLES_DEF = 780;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WR    = 5'b01000,
        S_RD    = 5'b10000
    } state_t;

    function automatic logic [3:0] cmd_or_nop(input logic use_cmd, input logic [3:0] cmd);
        return use_cmd ? cmd : CMD_NOP;
    endfunction

endpackage

// File: rtl/sdram_arbit_if.sv
// Engine-side request/grant/command bundle and SDRAM pin outputs of the arbiter.
// slave = arbiter view, master = engines/sdram top view.
interface sdram_arbit_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic [3:0]        ref_cmd;
    logic [ADDR_W-1:0] ref_addr;
    logic              flag_ref_end;
    logic              wr_req;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BA_W-1:0]   wr_bank;
    logic              flag_wr_end;
    logic              rd_req;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BA_W-1:0]   rd_bank;
    logic              flag_rd_end;

    logic              ref_req;
    logic              ref_en;
    logic              wr_en;
    logic              rd_en;
    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_ba;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  ref_cmd, ref_addr, flag_ref_end,
        input  wr_req, wr_cmd, wr_addr, wr_bank, flag_wr_end,
        input  rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
        output ref_req, ref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_addr, sdram_ba
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output ref_cmd, ref_addr, flag_ref_end,
        output wr_req, wr_cmd, wr_addr, wr_bank, flag_wr_end,
        output rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
        input  ref_req, ref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_addr, sdram_ba
    );

endinterface

// File: rtl/sdram_arbit_ref_timer.sv
// Auto-refresh interval timer: free-runs once the arbiter leaves init and raises ref_req
// every REF_CYCLES cycles; a single pending flag, so overlapping expiries collapse into one.
module sdram_arbit_ref_timer #(
    parameter int REF_CYCLES = 780
) (
    input  logic sclk,
    input  logic s_rst,
    input  logic run,
    input  logic ref_en,
    output logic ref_req
);

    localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             expire;

    assign expire = run && (cnt == LAST);

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            cnt     <= '0;
            ref_req <= 1'b0;
        end else begin
            if (!run || expire)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            // a new expiry outranks the grant clearing the previous one
            if (expire)
                ref_req <= 1'b1;
            else if (ref_en)
                ref_req <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command scheduler: init hold, AREF > WR > RD arbitration, one-cycle grants, pin mux.
// `define SDRAM_ARB_RR_EN switches WR/RD to round-robin; refresh stays highest priority.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int REF_CYCLES = REF_CYCLES_DEF,
    parameter int ADDR_W     = 13,
    parameter int BA_W       = 2
) (
    input  logic            sclk,
    input  logic            s_rst,
    sdram_arbit_if.slave    bus
);

    state_t state, state_nxt;
    logic   ref_en_nxt, wr_en_nxt, rd_en_nxt;
    logic   wr_first;
    logic   ref_req;

    logic [3:0]        cmd_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [BA_W-1:0]   ba_mux;

    sdram_arbit_ref_timer #(
        .REF_CYCLES (REF_CYCLES)
    ) u_ref_timer (
        .sclk    (sclk),
        .s_rst   (s_rst),
        .run     (state != S_INIT),
        .ref_en  (bus.ref_en),
        .ref_req (ref_req)
    );

    assign bus.ref_req = ref_req;

`ifdef SDRAM_ARB_RR_EN
    // 1 = write engine was served last; reset favours write first
    logic last_wr;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst)
            last_wr <= 1'b0;
        else if (wr_en_nxt)
            last_wr <= 1'b1;
        else if (rd_en_nxt)
            last_wr <= 1'b0;
    end

    assign wr_first = bus.wr_req && !(bus.rd_req && last_wr);
`else
    assign wr_first = bus.wr_req;
`endif

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state      <= S_INIT;
            bus.ref_en <= 1'b0;
            bus.wr_en  <= 1'b0;
            bus.rd_en  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bus.ref_en <= ref_en_nxt;
            bus.wr_en  <= wr_en_nxt;
            bus.rd_en  <= rd_en_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ref_en_nxt = 1'b0;
        wr_en_nxt  = 1'b0;
        rd_en_nxt  = 1'b0;
        unique case (state)
            S_INIT:  if (bus.init_end) state_nxt = S_ARBIT;
            S_ARBIT: begin
                if (ref_req) begin
                    state_nxt  = S_AREF;
                    ref_en_nxt = 1'b1;
                end else if (wr_first) begin
                    state_nxt = S_WR;
                    wr_en_nxt = 1'b1;
                end else if (bus.rd_req) begin
                    state_nxt = S_RD;
                    rd_en_nxt = 1'b1;
                end
            end
            S_AREF:  if (bus.flag_ref_end) state_nxt = S_ARBIT;
            S_WR:    if (bus.flag_wr_end)  state_nxt = S_ARBIT;
            S_RD:    if (bus.flag_rd_end)  state_nxt = S_ARBIT;
            default: state_nxt = S_INIT;
        endcase
    end

    // engine commands pass straight through; NOP while reset is held
    always_comb begin
        cmd_mux  = CMD_NOP;
        addr_mux = '0;
        ba_mux   = '0;
        if (!s_rst) begin
            unique case (state)
                S_INIT: begin
                    cmd_mux  = bus.init_cmd;
                    addr_mux = bus.init_addr;
                end
                S_AREF: begin
                    cmd_mux  = bus.ref_cmd;
                    addr_mux = bus.ref_addr;
                end
                S_WR: begin
                    cmd_mux  = bus.wr_cmd;
                    addr_mux = bus.wr_addr;
                    ba_mux   = bus.wr_bank;
                end
                S_RD: begin
                    cmd_mux  = bus.rd_cmd;
                    addr_mux = bus.rd_addr;
                    ba_mux   = bus.rd_bank;
                end
                default: cmd_mux = cmd_or_nop(1'b0, bus.init_cmd);
            endcase
        end
    end

    assign bus.sdram_cke = 1'b1;
    assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd_mux;
    assign bus.sdram_addr = addr_mux;
    assign bus.sdram_ba   = ba_mux;

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized scoreboard bench for sdram_arbit: a bus-ownership reference model predicts each
// cycle's grants, refresh flag and pin owner; a negedge monitor pops and compares.
module tb_sdram_arbit;

    localparam int R      = 16;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;

`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam int OWN_INIT = 0, OWN_ARB = 1, OWN_REF = 2, OWN_WR = 3, OWN_RD = 4;
    localparam int G_NONE = 0, G_REF = 1, G_WR = 2, G_RD = 3;

    typedef struct {
        int own;
        bit ref_req;
        int grant;
    } exp_t;

    logic sclk = 1'b0;
    logic s_rst;

    sdram_arbit_if #(.ADDR_W(ADDR_W), .BA_W(BA_W)) bus();

    sdram_arbit #(
        .REF_CYCLES (R),
        .ADDR_W     (ADDR_W),
        .BA_W       (BA_W)
    ) dut (
        .sclk  (sclk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];
    bit   started = 1'b0;

    // reference model state: who owns the bus, cycles since leaving init, pending refresh
    int m_own    = OWN_INIT;
    int m_run    = 0;
    bit m_pend   = 1'b0;
    int m_g      = G_NONE;
    bit m_lastwr = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge sclk) begin
        exp_t e;
        int   own_n, run_n, g_n;
        bit   pend_n, lw_n, wr_pick;
        if (s_rst) begin
            own_n = OWN_INIT; run_n = 0; pend_n = 1'b0; g_n = G_NONE; lw_n = 1'b0;
        end else begin
            own_n  = m_own;
            g_n    = G_NONE;
            lw_n   = m_lastwr;
            run_n  = (m_own == OWN_INIT) ? 0 : m_run + 1;
            pend_n = (m_g == G_REF) ? 1'b0 : m_pend;
            if (m_own != OWN_INIT && (m_run % R) == R - 1) pend_n = 1'b1;
            wr_pick = bus.wr_req && !(RR && bus.rd_req && m_lastwr);
            case (m_own)
                OWN_INIT: if (bus.init_end) own_n = OWN_ARB;
                OWN_ARB: begin
                    if (m_pend) begin own_n = OWN_REF; g_n = G_REF; end
                    else if (wr_pick) begin own_n = OWN_WR; g_n = G_WR; lw_n = 1'b1; end
                    else if (bus.rd_req) begin own_n = OWN_RD; g_n = G_RD; lw_n = 1'b0; end
                end
                OWN_REF: if (bus.flag_ref_end) own_n = OWN_ARB;
                OWN_WR:  if (bus.flag_wr_end)  own_n = OWN_ARB;
                OWN_RD:  if (bus.flag_rd_end)  own_n = OWN_ARB;
                default: own_n = OWN_INIT;
            endcase
        end
        m_own    <= own_n;
        m_run    <= run_n;
        m_pend   <= pend_n;
        m_g      <= g_n;
        m_lastwr <= lw_n;
        e.own     = own_n;
        e.ref_req = pend_n;
        e.grant   = g_n;
        q.push_back(e);
        started <= 1'b1;
    end

    always @(negedge sclk) begin
        exp_t       e;
        logic [3:0] ecmd;
        int         eaddr, eba;
        if (started) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = q.pop_front();
                if (s_rst) begin
                    e.own = -1; e.ref_req = 1'b0; e.grant = G_NONE;
                end
                ecmd = 4'b0111; eaddr = 0; eba = 0;
                case (e.own)
                    OWN_INIT: begin ecmd = bus.init_cmd; eaddr = int'(bus.init_addr); end
                    OWN_REF:  begin ecmd = bus.ref_cmd;  eaddr = int'(bus.ref_addr);  end
                    OWN_WR:   begin ecmd = bus.wr_cmd; eaddr = int'(bus.wr_addr); eba = int'(bus.wr_bank); end
                    OWN_RD:   begin ecmd = bus.rd_cmd; eaddr = int'(bus.rd_addr); eba = int'(bus.rd_bank); end
                    default:  ;
                endcase
                check("ref_req", int'(bus.ref_req), int'(e.ref_req));
                check("ref_en",  int'(bus.ref_en),  int'(e.grant == G_REF));
                check("wr_en",   int'(bus.wr_en),   int'(e.grant == G_WR));
                check("rd_en",   int'(bus.rd_en),   int'(e.grant == G_RD));
                check("cke",     int'(bus.sdram_cke), 1);
                check("cmd", int'({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n}),
                      int'(ecmd));
                check("addr", int'(bus.sdram_addr), eaddr);
                check("ba",   int'(bus.sdram_ba),   eba);
            end
        end
    end

    task automatic step(input bit wr, input bit rd, input int pwr, input int prd, input int pref);
        @(posedge sclk);
        #1;
        bus.wr_req       = wr;
        bus.rd_req       = rd;
        bus.flag_wr_end  = ($urandom_range(0, 99) < pwr);
        bus.flag_rd_end  = ($urandom_range(0, 99) < prd);
        bus.flag_ref_end = ($urandom_range(0, 99) < pref);
        bus.init_cmd     = 4'($urandom);
        bus.init_addr    = ADDR_W'($urandom);
        bus.ref_cmd      = 4'($urandom);
        bus.ref_addr     = ADDR_W'($urandom);
        bus.wr_cmd       = 4'($urandom);
        bus.wr_addr      = ADDR_W'($urandom);
        bus.wr_bank      = BA_W'($urandom);
        bus.rd_cmd       = 4'($urandom);
        bus.rd_addr      = ADDR_W'($urandom);
        bus.rd_bank      = BA_W'($urandom);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    initial begin
        int k;
        s_rst = 1'b1;
        bus.init_end = 1'b0;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.flag_wr_end = 1'b0; bus.flag_rd_end = 1'b0; bus.flag_ref_end = 1'b0;
        bus.init_cmd = 4'b0111; bus.init_addr = '0;
        bus.ref_cmd = 4'b0111;  bus.ref_addr = '0;
        bus.wr_cmd = 4'b0111; bus.wr_addr = '0; bus.wr_bank = '0;
        bus.rd_cmd = 4'b0111; bus.rd_addr = '0; bus.rd_bank = '0;

        // init hold: requests present but no grant before init_end
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        s_rst = 1'b0;
        for (int i = 3; i < 20; i++) step(1, 1, 0, 0, 0);
        bus.init_end = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 50);

        // single write with release
        for (int i = 0; i < 12; i++) step(1, 0, (i % 4 == 3) ? 100 : 0, 0, 50);

        // both engines requesting continuously
        for (int i = 0; i < 60; i++) step(1, 1, 35, 35, 40);

        // long write with no release: refresh expires several times but is granted once
        k = 0;
        while (m_own != OWN_ARB && k < 200) begin step(0, 0, 50, 50, 50); k++; end
        if (k >= 200) timeout("reach_arbit");
        for (int i = 0; i < 3 * R + 5; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 100, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 30);

        // random traffic including spurious end flags
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 20, 20, 25);

        // reset while reading
        k = 0;
        while (m_own != OWN_RD && k < 300) begin step(0, 1, 30, 0, 40); k++; end
        if (k >= 300) timeout("reach_read");
        s_rst = 1'b1;
        bus.init_end = 1'b0;
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        s_rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
        bus.init_end = 1'b1;
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 25, 25, 30);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge sclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
